rd_burst_issuer: RTL and testbench

- AXI4 read-side transfer engine for kernel memory ports.
- Takes a start request, a byte offset and a byte length, then splits the transfer into fixed-length AR bursts.
- Limits in-flight bursts with an internal up/down outstanding-transaction counter, and forwards R beats to an AXI4-Stream output.
- Pulses done when all data has been delivered.

---
 rtl/rd_burst_issuer.sv | 124 ++++++++++++
 tb/tb_rd_burst_issuer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rd_burst_issuer.sv
// rd_burst_issuer: splits a byte-range read into fixed-length AXI4 AR bursts and streams R beats out on AXIS
module rd_burst_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic                         m_axi_rlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                         m_axis_tlast
);
    localparam int BPB = C_DATA_WIDTH / 8;
    localparam int LB  = $clog2(BPB);
    localparam int XW  = C_XFER_SIZE_WIDTH;
    localparam int AW  = C_ADDR_WIDTH;
    localparam int OW  = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int BSH = $clog2(C_BURST_LEN * BPB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   total_q, total_d, issued_q, issued_d, compl_q, compl_d;
    logic [7:0]      last_len_q, last_len_d, arlen_q, arlen_d;
    logic [AW-1:0]   base_q, base_d, araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [XW-1:0]   beats, bursts, issued_n;
    logic            ar_hs, rl_hs, last_burst;

    // beat and burst counts are rounded up so a partial beat or burst still gets fetched
    assign beats      = (ctrl_xfer_size_in_bytes >> LB) + XW'(|(ctrl_xfer_size_in_bytes & XW'(BPB - 1)));
    assign bursts     = (beats >> $clog2(C_BURST_LEN)) + XW'(|(beats & XW'(C_BURST_LEN - 1)));
    assign ar_hs      = arvalid_q && m_axi_arready;
    assign rl_hs      = m_axi_rvalid && m_axi_rready && m_axi_rlast && state_q == RUN;
    assign last_burst = compl_q == total_q - XW'(1);
    assign issued_n   = issued_q + XW'(ar_hs);

    assign ctrl_busy     = state_q != IDLE;
    assign ctrl_done     = state_q == DONE;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_rready  = m_axis_tready && ctrl_busy;
    assign m_axis_tvalid = m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = m_axi_rlast && last_burst;

    // next-state: accept start, issue ARs under the outstanding cap, finish on the last burst's RLAST
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        last_len_d = last_len_q;
        base_d     = base_q;
        issued_d   = issued_n;
        compl_d    = compl_q + XW'(rl_hs);
        outst_d    = outst_q + OW'(ar_hs) - OW'(rl_hs);
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        case (state_q)
            IDLE: if (ctrl_start) begin
                base_d     = ctrl_addr_offset & ~AW'(BPB - 1);
                total_d    = bursts;
                last_len_d = 8'((beats - XW'(1)) & XW'(C_BURST_LEN - 1));
                issued_d   = '0;
                compl_d    = '0;
                state_d    = ctrl_xfer_size_in_bytes == '0 ? DONE : RUN;
            end
            RUN: begin
                if (!arvalid_q || ar_hs) begin
                    arvalid_d = issued_n != total_q && outst_d < OW'(C_MAX_OUTSTANDING);
                    araddr_d  = base_q + (AW'(issued_n) << BSH);
                    arlen_d   = issued_n == total_q - XW'(1) ? last_len_q : 8'(C_BURST_LEN - 1);
                end
                if (rl_hs && last_burst) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any transfer in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            total_q    <= '0;
            last_len_q <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            compl_q    <= '0;
            outst_q    <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            last_len_q <= last_len_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            compl_q    <= compl_d;
            outst_q    <= outst_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
        end
    end
endmodule

// File: tb/tb_rd_burst_issuer.sv
// tb_rd_burst_issuer: randomized AXI slave and stream sink checked against a burst-list model
module tb_rd_burst_issuer;
    localparam int AW = 64, DW = 512, XW = 32, BL = 64, MO = 16, BPB = DW / 8;

    logic clk = 0, rst_n = 0;
    logic ctrl_start = 0, ctrl_busy, ctrl_done;
    logic [AW-1:0] ctrl_addr_offset = '0;
    logic [XW-1:0] ctrl_xfer_size_in_bytes = '0;
    logic m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rready, m_axi_rlast = 0;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0] m_axi_arlen;
    logic [DW-1:0] m_axi_rdata = '0, m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;

    int errors = 0, checks = 0;
    logic [63:0] ea[$];
    int el[$], rq[$];
    int outst, beat_idx, ar_count;
    longint beats_seen, tot_beats, tot_bursts;
    bit r_pend;
    logic [DW-1:0] r_cur = '0;

    rd_burst_issuer #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW),
                      .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // tmode: 0 random tready, 1 toggle, 2 always ready; r_hold: cycles with no R data and arready=1
    task automatic run_xfer(input logic [63:0] off, input longint size, input int tmode,
                            input int r_hold, input bit mid);
        logic [63:0] base, s_addr, a;
        logic [7:0] s_len;
        bit done_seen, stall;
        int c, l;
        ea.delete(); el.delete(); rq.delete();
        outst = 0; beat_idx = 0; ar_count = 0; beats_seen = 0; r_pend = 0;
        base = off & ~64'(BPB - 1);
        tot_beats = (size + BPB - 1) / BPB;
        tot_bursts = (tot_beats + BL - 1) / BL;
        for (longint k = 0; k < tot_bursts; k++) begin
            ea.push_back(base + 64'(k * BL * BPB));
            el.push_back(k == tot_bursts - 1 ? int'((tot_beats - 1) % BL) : BL - 1);
        end
        done_seen = 0; stall = 0; c = 0; s_addr = '0; s_len = '0;
        while (!done_seen && c < 20000) begin
            @(negedge clk);
            ctrl_start = (c == 0) || (mid && c == 30);
            ctrl_addr_offset = c == 0 ? off : 64'h999;
            ctrl_xfer_size_in_bytes = c == 0 ? 32'(size) : 32'd64;
            m_axi_arready = r_hold > 0 ? 1'b1 : 1'($urandom_range(0, 1));
            if (!r_pend && rq.size() > 0 && c >= r_hold && $urandom_range(0, 3) != 0) begin
                r_pend = 1;
                r_cur = rnd();
            end
            m_axi_rvalid = r_pend;
            m_axi_rdata = r_cur;
            m_axi_rlast = r_pend && beat_idx == rq[0];
            m_axis_tready = tmode == 1 ? 1'(c % 2) : tmode == 2 ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("busy", ctrl_busy, c > 0);
            chk("rready", m_axi_rready, m_axis_tready && c > 0);
            chk("tvalid", m_axis_tvalid, m_axi_rvalid);
            if (m_axi_rvalid) chk("tdata", m_axis_tdata, r_cur);
            if (r_hold > 0 && c == r_hold) begin
                chk("ar_cap", ar_count, MO);
                chk("ar_stop", m_axi_arvalid, 0);
            end
            if (stall) begin
                chk("ar_hold_v", m_axi_arvalid, 1);
                chk("ar_hold_a", m_axi_araddr, s_addr);
                chk("ar_hold_l", m_axi_arlen, s_len);
            end
            if (m_axi_arvalid) begin
                chk("ar_allowed", ea.size() > 0 && outst < MO, 1);
                if (m_axi_arready && ea.size() > 0) begin
                    a = ea.pop_front();
                    l = el.pop_front();
                    chk("araddr", m_axi_araddr, a);
                    chk("arlen", m_axi_arlen, l);
                    rq.push_back(l);
                    outst++;
                    ar_count++;
                end
            end
            stall = m_axi_arvalid && !m_axi_arready;
            s_addr = m_axi_araddr;
            s_len = m_axi_arlen;
            if (ctrl_done) begin
                done_seen = 1;
                chk("done_beats", beats_seen, tot_beats);
                chk("done_ars", ar_count, tot_bursts);
                if (size == 0) chk("done_lat", c <= 2, 1);
            end
            if (m_axi_rvalid && m_axis_tready && c > 0) begin
                chk("tlast", m_axis_tlast, beats_seen == tot_beats - 1);
                beats_seen++;
                r_pend = 0;
                if (m_axi_rlast) begin
                    void'(rq.pop_front());
                    outst--;
                    beat_idx = 0;
                end else beat_idx++;
            end
            c++;
        end
        if (!done_seen) chk("timeout", 0, 1);
        @(negedge clk);
        ctrl_start = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_arready = 0;
        #1;
        chk("idle_busy", ctrl_busy, 0);
        chk("idle_done", ctrl_done, 0);
        chk("ar_left", ea.size(), 0);
    endtask

    initial begin
        int cnt, n;
        repeat (3) @(negedge clk);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        rst_n = 1;
        run_xfer(64'h1000, 0, 0, 0, 0);
        run_xfer(64'h2000, 64, 0, 0, 0);
        run_xfer(64'h0, 4160, 0, 0, 0);
        run_xfer(64'h0, 65536, 0, 60, 0);
        run_xfer(64'h4000, 8192, 1, 0, 1);
        run_xfer(64'hFFFF_FFFF_FFFF_F000, 8192, 2, 0, 0);
        @(negedge clk);
        ctrl_start = 1; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = 32'd65536;
        m_axi_arready = 1; m_axi_rvalid = 0; m_axis_tready = 1;
        cnt = 0; n = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk);
            ctrl_start = 0;
            #1;
            if (m_axi_arvalid && m_axi_arready) cnt++;
            n++;
        end
        chk("pre_rst_ars", cnt, 3);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_busy", ctrl_busy, 0);
        chk("mid_rst_done", ctrl_done, 0);
        @(negedge clk);
        rst_n = 1; m_axi_arready = 0;
        run_xfer(64'h3000, 64, 2, 0, 0);
        repeat (4) run_xfer({$urandom, $urandom}, longint'($urandom_range(1, 20000)), 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
